uart_rx_frame_deser: RTL and testbench
======================================

// Module: uart_rx_frame_deser
// PURPOSE
//  Parametrised UART RX deserializer with its own frame FSM.
//  Takes one oversampled bit per bit period from the sampler and sends a whole frame downstream:
//  configurable data width and bit order, optional parity, stop-bit check.
//  Sits between the RX sampler/edge counter and the consumer, using a valid/ready output with overrun detection.
// PARAMETERS
//  PRESCALE     16   clk2 cycles per bit; edge_cnt runs 0..PRESCALE-1
//  DATA_WIDTH   8    data bits per frame, legal 5..9
//  MSB_FIRST    0    0: first received bit -> p_data[0]; 1: first bit -> p_data[DATA_WIDTH-1]
//  PARITY_EN    0    1: one parity bit follows the data bits
//  PARITY_ODD   0    0: even parity, 1: odd parity (ignored if PARITY_EN=0)
// PORTS
//  clk2          in   1                    oversampling clock
//  rst           in   1                    asynchronous reset, active-low
//  des_en        in   1                    frame enable from RX control; low aborts the frame
//  frame_start   in   1                    1-cycle pulse: start bit validated
//  sampled_data  in   1                    majority-voted bit from sampler
//  edge_cnt      in   $clog2(PRESCALE)     edge counter within the current bit
//  p_data        out  DATA_WIDTH           received data, stable while out_valid=1
//  out_valid     out  1                    p_data/parity_err/stop_err valid
//  out_ready     in   1                    consumer accepts on clk2 edge with out_valid=1
//  parity_err    out  1                    parity mismatch for the held frame (0 if !PARITY_EN)
//  stop_err      out  1                    stop bit sampled 0 for the held frame
//  overrun       out  1                    1-cycle pulse: frame completed while holding register full
//  busy          out  1                    FSM not IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; shift reg, bit_idx, parity acc = 0; all outputs 0.
//  - Sample strobe: smp = des_en && (edge_cnt == PRESCALE-1). It is evaluated only in the DATA, PARITY and STOP states.
//  - FSM states: IDLE, DATA, PARITY, STOP.
//    IDLE: frame_start && des_en -> DATA. On entry, bit_idx=0 and acc=0; the shift register is not cleared.
//      In IDLE, smp and sampled_data are ignored.
//    DATA: on smp, shift in the bit.
//      MSB_FIRST=0: sr <= {bit, sr[W-1:1]}.
//      MSB_FIRST=1: sr <= {sr[W-2:0], bit}.
//      Also acc ^= bit and bit_idx++.
//      On the smp where bit_idx==DATA_WIDTH-1: go to PARITY if PARITY_EN, else STOP.
//    PARITY: on smp, perr = (acc ^ bit) != PARITY_ODD, then -> STOP.
//    STOP: on smp, -> IDLE and complete the frame with serr = ~bit.
//  - Frame completion, registered on the stop-sample edge, so outputs change 1 cycle after the strobe cycle:
//    - If the holding register is free (out_valid=0, or out_ready=1 this cycle): p_data<=sr, parity_err<=perr,
//      stop_err<=serr, out_valid<=1.
//    - Otherwise the new frame is dropped, the held data is unchanged, and overrun pulses for 1 cycle.
//  - Handshake:
//    - While out_valid=1, p_data and the flags hold.
//    - On an edge with out_valid && out_ready, out_valid clears, unless a frame completes on that same edge, in which case it reloads and stays 1.
//    - out_ready is ignored when out_valid=0.
//  - Abort: des_en=0 in any non-IDLE state -> IDLE on the next edge. No output and no flags; the holding register is untouched.
//  - frame_start while not IDLE: ignored.
//  - Reset asserted mid-frame: everything returns to reset values immediately; a held frame is lost.
//  - Widths: bit_idx is $clog2(DATA_WIDTH+1) bits, and it never wraps within a frame.
//  - Latency: p_data is valid 1 clk2 after the stop-bit strobe. The total frame is (1+DATA_WIDTH+PARITY_EN+1)*PRESCALE cycles from the start bit.
// TESTING
//  T1 defaults: send 0xA5 LSB-first with stop=1
//     -> out_valid rises 1 cycle after the stop strobe, p_data=8'hA5, parity_err=0, stop_err=0.
//  T2 PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit=1
//     -> p_data=8'h03, parity_err=1.
//     Repeat with parity bit=0 -> parity_err=0.
//  T3 MSB_FIRST=1, DATA_WIDTH=7: send bits 1,0,0,0,0,0,1
//     -> p_data=7'h41.
//     Send stop=0 -> stop_err=1, and the frame is still delivered.
//  T4 out_ready=0: send 0x11 then 0x22
//     -> p_data stays 0x11, overrun pulses for exactly 1 cycle on the 2nd stop strobe.
//     Then with out_ready=1 on the same edge as the 3rd frame's stop -> out_valid stays 1 and p_data=that frame.
//  T5 drop des_en after 3 data bits
//     -> busy=0 next cycle, no out_valid, prior p_data unchanged.
//     A fresh frame 0x5A then decodes correctly.
//  T6 assert rst mid-DATA with out_valid=1
//     -> all outputs 0 immediately; frame_start pulses in non-IDLE states have no effect.

Source files
------------

// File: rtl/uart_rx_frame_deser.sv
// uart_rx_frame_deser: turns per-bit UART samples into parallel frames with parity/stop checks behind a valid/ready holding register
module uart_rx_frame_deser #(
  parameter int PRESCALE   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk2,
  input  logic                        rst,
  input  logic                        des_en,
  input  logic                        frame_start,
  input  logic                        sampled_data,
  input  logic [$clog2(PRESCALE)-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]       p_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        parity_err,
  output logic                        stop_err,
  output logic                        overrun,
  output logic                        busy
);
  localparam int EW = $clog2(PRESCALE);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] sr, sr_shift;
  logic [IW-1:0] bit_idx;
  logic acc, perr, smp, last_bit, start, done, free;
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? DATA : IDLE;
      DATA:    nxt = !des_en ? IDLE : (smp && last_bit) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  nxt = !des_en ? IDLE : smp ? STOP : PARITY;
      STOP:    nxt = (!des_en || smp) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // a frame that completes while the register is held and not being read is dropped
  always_comb begin
    smp = des_en && (edge_cnt == EW'(PRESCALE - 1));
    last_bit = bit_idx == IW'(DATA_WIDTH - 1);
    start = (state == IDLE) && frame_start && des_en;
    done = (state == STOP) && smp;
    free = !out_valid || out_ready;
    sr_shift = (MSB_FIRST != 0) ? {sr[DATA_WIDTH-2:0], sampled_data} : {sampled_data, sr[DATA_WIDTH-1:1]};
    busy = state != IDLE;
  end
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) begin
      sr <= '0;
      bit_idx <= '0;
      acc <= 1'b0;
      perr <= 1'b0;
    end else if (start) begin
      bit_idx <= '0;
      acc <= 1'b0;
      perr <= 1'b0;
    end else if (state == DATA && smp) begin
      sr <= sr_shift;
      acc <= acc ^ sampled_data;
      bit_idx <= bit_idx + IW'(1);
    end else if (state == PARITY && smp) begin
      perr <= (acc ^ sampled_data) != 1'(PARITY_ODD);
    end
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) begin
      p_data <= '0;
      out_valid <= 1'b0;
      parity_err <= 1'b0;
      stop_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done && !free;
      if (done && free) begin
        p_data <= sr;
        parity_err <= perr;
        stop_err <= ~sampled_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// tb_uart_rx_frame_deser: directed frames into three parameterisations, scoreboard monitor checks each accepted frame
module tb_uart_rx_frame_deser;
  localparam int P = 16;
  logic clk2 = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic sampled_data = 1'b1;
  logic [3:0] edge_cnt = '0;
  logic [2:0] des_en = '0;
  logic [2:0] out_ready = '0;
  logic [7:0] pd_a, pd_b;
  logic [6:0] pd_c;
  logic [2:0] ov, pe, se, orun, bsy;
  logic [8:0] pd [3];
  int checks = 0;
  int errors = 0;
  typedef struct {int id; logic [8:0] d; logic pe; logic se;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  always #5 clk2 = ~clk2;
  assign pd[0] = {1'b0, pd_a};
  assign pd[1] = {1'b0, pd_b};
  assign pd[2] = {2'b0, pd_c};
  uart_rx_frame_deser dut_a (
    .clk2(clk2), .rst(rst), .des_en(des_en[0]), .frame_start(frame_start),
    .sampled_data(sampled_data), .edge_cnt(edge_cnt), .p_data(pd_a), .out_valid(ov[0]),
    .out_ready(out_ready[0]), .parity_err(pe[0]), .stop_err(se[0]), .overrun(orun[0]), .busy(bsy[0]));
  uart_rx_frame_deser #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk2(clk2), .rst(rst), .des_en(des_en[1]), .frame_start(frame_start),
    .sampled_data(sampled_data), .edge_cnt(edge_cnt), .p_data(pd_b), .out_valid(ov[1]),
    .out_ready(out_ready[1]), .parity_err(pe[1]), .stop_err(se[1]), .overrun(orun[1]), .busy(bsy[1]));
  uart_rx_frame_deser #(.DATA_WIDTH(7), .MSB_FIRST(1)) dut_c (
    .clk2(clk2), .rst(rst), .des_en(des_en[2]), .frame_start(frame_start),
    .sampled_data(sampled_data), .edge_cnt(edge_cnt), .p_data(pd_c), .out_valid(ov[2]),
    .out_ready(out_ready[2]), .parity_err(pe[2]), .stop_err(se[2]), .overrun(orun[2]), .busy(bsy[2]));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, r);
    end
  endtask
  // an accepted frame is one seen with out_valid && out_ready before the edge that consumes it
  always @(negedge clk2)
    for (int i = 0; i < 3; i++)
      if (rst && ov[i] && out_ready[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame dut%0d got %h want none", i, pd[i]);
        end else begin
          e = exp_q.pop_front();
          chk("frame {id,data,perr,serr}", 32'({i[1:0], pd[i], pe[i], se[i]}),
              32'({e.id[1:0], e.d, e.pe, e.se}));
        end
      end
  task automatic tick;
    @(posedge clk2);
    #1;
  endtask
  task automatic send_bit(input logic b, input int n, input bit gl);
    for (int k = 0; k < n; k++) begin
      edge_cnt = 4'(k);
      sampled_data = b;
      frame_start = gl && k == 5;
      tick();
    end
    frame_start = 1'b0;
  endtask
  task automatic start_frame(input int id);
    des_en = 3'b000;
    des_en[id] = 1'b1;
    edge_cnt = '0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic strobe;
    edge_cnt = 4'(P - 1);
    tick();
  endtask
  task automatic frame_pre(input int id, input int w, input bit msb, input logic [8:0] v, input bit hp,
                           input logic par, input logic stp, input bit push, input logic epe, input bit g);
    start_frame(id);
    for (int k = 0; k < w; k++) send_bit(msb ? v[w-1-k] : v[k], P, g && k == 2);
    if (hp) send_bit(par, P, 1'b0);
    if (push) exp_q.push_back('{id, v, epe, ~stp});
    send_bit(stp, P - 1, g);
  endtask
  task automatic frame(input int id, input int w, input bit msb, input logic [8:0] v, input bit hp,
                       input logic par, input logic stp, input bit push, input logic epe, input bit g);
    frame_pre(id, w, msb, v, hp, par, stp, push, epe, g);
    strobe();
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_flags", 32'({ov, pe, se, orun, bsy}), 32'(0));
    chk("reset_pdata", 32'({pd_a, pd_b, pd_c}), 32'(0));
    rst = 1'b1;
    out_ready = 3'b110;
    tick();
    // T1: default LSB-first 0xA5
    frame_pre(0, 8, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_valid_before_strobe", 32'(ov[0]), 32'(0));
    strobe();
    chk("t1_valid_after_strobe", 32'(ov[0]), 32'(1));
    chk("t1_pdata", 32'(pd_a), 32'h0A5);
    chk("t1_flags", 32'({pe[0], se[0], orun[0]}), 32'(0));
    out_ready[0] = 1'b1;
    tick();
    chk("t1_valid_cleared", 32'(ov[0]), 32'(0));
    // T2: even parity, 0x03 with wrong then right parity bit
    frame(1, 8, 1'b0, 9'h003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_perr_set", 32'({ov[1], pd_b, pe[1]}), 32'({1'b1, 8'h03, 1'b1}));
    frame(1, 8, 1'b0, 9'h003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_perr_clear", 32'({ov[1], pd_b, pe[1]}), 32'({1'b1, 8'h03, 1'b0}));
    // T3: MSB-first 7-bit, then bad stop bit
    frame(2, 7, 1'b1, 9'h041, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_pdata", 32'({ov[2], pd_c}), 32'({1'b1, 7'h41}));
    frame(2, 7, 1'b1, 9'h02B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_stop_err", 32'({ov[2], pd_c, se[2]}), 32'({1'b1, 7'h2B, 1'b1}));
    // T4: hold 0x11, drop 0x22 with overrun, replace on same-edge accept
    out_ready[0] = 1'b0;
    frame(0, 8, 1'b0, 9'h011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_first_held", 32'({ov[0], pd_a, orun[0]}), 32'({1'b1, 8'h11, 1'b0}));
    frame(0, 8, 1'b0, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_overrun_pulse", 32'({ov[0], pd_a, orun[0]}), 32'({1'b1, 8'h11, 1'b1}));
    tick();
    chk("t4_overrun_one_cycle", 32'(orun[0]), 32'(0));
    frame_pre(0, 8, 1'b0, 9'h033, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready[0] = 1'b1;
    strobe();
    out_ready[0] = 1'b0;
    chk("t4_reload_same_edge", 32'({ov[0], pd_a, orun[0]}), 32'({1'b1, 8'h33, 1'b0}));
    tick();
    out_ready[0] = 1'b1;
    tick();
    chk("t4_drained", 32'(ov[0]), 32'(0));
    // T5: abort after three data bits
    start_frame(0);
    for (int k = 0; k < 3; k++) send_bit(k[0], P, 1'b0);
    chk("t5_busy_before_abort", 32'(bsy[0]), 32'(1));
    des_en[0] = 1'b0;
    tick();
    chk("t5_busy_after_abort", 32'(bsy[0]), 32'(0));
    repeat (40) tick();
    chk("t5_no_output", 32'({ov[0], pd_a, orun[0]}), 32'({1'b0, 8'h33, 1'b0}));
    frame(0, 8, 1'b0, 9'h05A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_fresh_frame", 32'({ov[0], pd_a}), 32'({1'b1, 8'h5A}));
    tick();
    // T6: reset mid-DATA while holding a frame
    out_ready[0] = 1'b0;
    frame(0, 8, 1'b0, 9'h096, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_held", 32'({ov[0], pd_a}), 32'({1'b1, 8'h96}));
    start_frame(0);
    send_bit(1'b1, P, 1'b0);
    send_bit(1'b0, P, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_async_reset", 32'({ov[0], pd_a, pe[0], se[0], orun[0], bsy[0]}), 32'(0));
    tick();
    rst = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    frame(0, 8, 1'b0, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_start_ignored_busy", 32'({ov[0], pd_a, bsy[0]}), 32'({1'b1, 8'h3C, 1'b0}));
    repeat (4) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
